// File: rtl/imm_encoder_pkg.sv
// Shared constants for the immediate encoder: ImmSrc selector codes and
// FSM state encoding.
package imm_encoder_pkg;

  // ImmSrc selector values (match the datapath extender)
  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEARCH = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

endpackage

// File: rtl/imm_rot_check.sv
// Tests one rotation candidate for a DP rotated immediate: the value rotated
// left by 2*rot must fit in the low 8 bits.
module imm_rot_check (
  input  logic [31:0] value,
  input  logic [3:0]  rot,
  output logic        hit,
  output logic [7:0]  imm8
);

  logic [63:0] doubled;
  logic [63:0] shifted;
  logic [31:0] cand;

  // Rotate-left via a doubled word so rot=0 needs no special case
  always_comb begin
    doubled = {value, value};
    shifted = doubled << {rot, 1'b0};
    cand    = shifted[63:32];
    hit     = (cand[31:8] == 24'd0);
    imm8    = cand[7:0];
  end

endmodule

// File: rtl/imm_encoder.sv
// Inverse immediate extender: finds the 24-bit instruction immediate field
// that extends back to a given 32-bit constant. DP rotated immediates are
// searched one rotation per cycle, smallest rotation first.
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int ROT_STEPS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_value,
  input  logic [1:0]  req_src,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [23:0] rsp_field,
  output logic        rsp_ok
);

  localparam logic [3:0] ROT_LAST = 4'(ROT_STEPS - 1);

  logic [1:0]  state_reg;
  logic [3:0]  rot_reg;
  logic [31:0] value_reg;
  logic [1:0]  src_reg;
  logic [23:0] field_reg;
  logic        ok_reg;

  logic        rot_hit;
  logic [7:0]  rot_imm8;
  logic        ok_next;
  logic [23:0] field_next;
  logic        finish_next;

  imm_rot_check u_rot_check (
    .value (value_reg),
    .rot   (rot_reg),
    .hit   (rot_hit),
    .imm8  (rot_imm8)
  );

  // Evaluate the current candidate for the captured selector
  always_comb begin
    ok_next     = 1'b0;
    field_next  = 24'd0;
    finish_next = 1'b1;
    case (src_reg)
      IMM_DP: begin
        ok_next     = rot_hit;
        field_next  = {12'd0, rot_reg, rot_imm8};
        finish_next = rot_hit || (rot_reg == ROT_LAST);
      end
      IMM_MEM: begin
        ok_next    = (value_reg[31:12] == 20'd0);
        field_next = {12'd0, value_reg[11:0]};
      end
      IMM_BR: begin
        // Word aligned, and bits 31:25 all copies of the field sign bit
        ok_next    = (value_reg[1:0] == 2'b00) &&
                     ((value_reg[31:25] == 7'h00) || (value_reg[31:25] == 7'h7F));
        field_next = value_reg[25:2];
      end
      default: begin
        ok_next = 1'b0;
      end
    endcase
    if (!ok_next) begin
      field_next = 24'd0;
    end
  end

  // FSM, rotation counter, capture and response registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      rot_reg   <= 4'd0;
      value_reg <= 32'd0;
      src_reg   <= 2'd0;
      field_reg <= 24'd0;
      ok_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            value_reg <= req_value;
            src_reg   <= req_src;
            rot_reg   <= 4'd0;
            state_reg <= ST_SEARCH;
          end
        end
        ST_SEARCH: begin
          if (finish_next) begin
            field_reg <= field_next;
            ok_reg    <= ok_next;
            state_reg <= ST_DONE;
          end else begin
            rot_reg <= rot_reg + 4'd1;
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // Ready is held low while reset is asserted even though the state is IDLE
  assign req_ready = (state_reg == ST_IDLE) && reset;
  assign rsp_valid = (state_reg == ST_DONE);
  assign rsp_field = field_reg;
  assign rsp_ok    = ok_reg;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: table of vectors with hand-computed
// expectations, plus sequences for response stall and reset abort.
module tb_imm_encoder;

  localparam int ROT_STEPS = 16;
  localparam int LAT_LIMIT = ROT_STEPS + 10;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_value;
  logic [1:0]  req_src;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [23:0] rsp_field;
  logic        rsp_ok;

  int n_checks = 0;
  int n_fail   = 0;

  imm_encoder #(.ROT_STEPS(ROT_STEPS)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_value (req_value),
    .req_src   (req_src),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_field (rsp_field),
    .rsp_ok    (rsp_ok)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [1:0]  src;
    logic [31:0] value;
    logic        ok;
    logic [23:0] field;
    int          lat;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference extender: the field with its selector must rebuild the value
  function automatic logic [31:0] extend(input logic [23:0] f, input logic [1:0] src);
    logic [63:0] d;
    logic [31:0] r;
    r = 32'd0;
    case (src)
      2'b00: begin
        d = {32'd0, 24'd0, f[7:0]} << (32 - 2 * int'(f[11:8]));
        r = d[63:32] | d[31:0];
      end
      2'b01: r = {20'd0, f[11:0]};
      2'b10: r = {{6{f[23]}}, f, 2'b00};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Present a request, return the edge count (accept edge included) to rsp_valid
  task automatic issue(input logic [1:0] src, input logic [31:0] value, output int lat);
    @(negedge clk);
    check("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_src   = src;
    req_value = value;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_value = 32'hDEAD_BEEF;
    req_src   = 2'b11;
    lat = 1;
    while (!rsp_valid && lat < LAT_LIMIT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("rsp_valid_within_bound", {31'd0, rsp_valid}, 32'd1);
  endtask

  // Accept the response and confirm the handshake returns to IDLE
  task automatic accept_rsp();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("rsp_valid_after_accept", {31'd0, rsp_valid}, 32'd0);
    check("req_ready_after_accept", {31'd0, req_ready}, 32'd1);
  endtask

  int lat;
  int seen;

  initial begin
    vecs[0]  = '{2'b00, 32'h0000_00FF, 1'b1, 24'h0000FF, 2};
    vecs[1]  = '{2'b00, 32'hFF00_0000, 1'b1, 24'h0004FF, 6};
    vecs[2]  = '{2'b00, 32'h0000_0102, 1'b0, 24'h000000, 17};
    vecs[3]  = '{2'b00, 32'h0000_0000, 1'b1, 24'h000000, 2};
    vecs[4]  = '{2'b00, 32'h0000_03FC, 1'b1, 24'h000FFF, 17};
    vecs[5]  = '{2'b00, 32'hF000_000F, 1'b1, 24'h0002FF, 4};
    vecs[6]  = '{2'b00, 32'h0000_0100, 1'b1, 24'h000C01, 14};
    vecs[7]  = '{2'b01, 32'h0000_0ABC, 1'b1, 24'h000ABC, 2};
    vecs[8]  = '{2'b01, 32'h0000_1000, 1'b0, 24'h000000, 2};
    vecs[9]  = '{2'b01, 32'h0000_0FFF, 1'b1, 24'h000FFF, 2};
    vecs[10] = '{2'b10, 32'hFFFF_FFF8, 1'b1, 24'hFFFFFE, 2};
    vecs[11] = '{2'b10, 32'h0000_0006, 1'b0, 24'h000000, 2};
    vecs[12] = '{2'b10, 32'h0400_0000, 1'b0, 24'h000000, 2};
    vecs[13] = '{2'b10, 32'h01FF_FFFC, 1'b1, 24'h7FFFFF, 2};
    vecs[14] = '{2'b11, 32'h0000_0004, 1'b0, 24'h000000, 2};

    reset     = 1'b0;
    req_valid = 1'b0;
    req_value = 32'd0;
    req_src   = 2'b00;
    rsp_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_req_ready", {31'd0, req_ready}, 32'd0);
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_rsp_field", {8'd0, rsp_field}, 32'd0);
    check("reset_rsp_ok", {31'd0, rsp_ok}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("release_req_ready", {31'd0, req_ready}, 32'd1);

    // Table-driven vectors
    for (int i = 0; i < 15; i++) begin
      issue(vecs[i].src, vecs[i].value, lat);
      $display("txn %0d: src=%0d value=0x%08h ok=%0d field=0x%06h lat=%0d",
               i, vecs[i].src, vecs[i].value, rsp_ok, rsp_field, lat);
      check($sformatf("v%0d_ok", i), {31'd0, rsp_ok}, {31'd0, vecs[i].ok});
      check($sformatf("v%0d_field", i), {8'd0, rsp_field}, {8'd0, vecs[i].field});
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      if (rsp_ok) begin
        check($sformatf("v%0d_roundtrip", i), extend(rsp_field, vecs[i].src), vecs[i].value);
      end
      accept_rsp();
    end

    // Response held while rsp_ready stays low
    issue(2'b00, 32'hFF00_0000, lat);
    $display("txn stall: ok=%0d field=0x%06h lat=%0d", rsp_ok, rsp_field, lat);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("stall_rsp_field", {8'd0, rsp_field}, 32'h0000_04FF);
      check("stall_rsp_ok", {31'd0, rsp_ok}, 32'd1);
      check("stall_req_ready", {31'd0, req_ready}, 32'd0);
    end
    accept_rsp();

    // Reset during SEARCH aborts the request
    @(negedge clk);
    req_valid = 1'b1;
    req_src   = 2'b00;
    req_value = 32'h0000_0102;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midsearch_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("abort_req_ready", {31'd0, req_ready}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) seen++;
    end
    check("abort_no_response", seen, 0);
    check("abort_idle_ready", {31'd0, req_ready}, 32'd1);
    $display("txn reset-abort: responses seen after abort=%0d", seen);

    issue(2'b01, 32'h0000_0ABC, lat);
    $display("txn post-abort: ok=%0d field=0x%06h lat=%0d", rsp_ok, rsp_field, lat);
    check("post_abort_ok", {31'd0, rsp_ok}, 32'd1);
    check("post_abort_field", {8'd0, rsp_field}, 32'h0000_0ABC);
    check("post_abort_latency", lat, 2);

    // Reset while in DONE drops the pending response
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("done_abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("done_abort_rsp_ok", {31'd0, rsp_ok}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("done_abort_req_ready", {31'd0, req_ready}, 32'd1);
    $display("txn reset-in-done: rsp_valid=%0d", rsp_valid);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
